// File: rtl/rename_ctrl.sv
// Rename-stage controller: owns the 32-entry physical-register free list,
// drives the external RAT ports, and registers one renamed instruction for dispatch.
module rename_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_sr1,
  input  logic [4:0] in_sr2,
  input  logic [4:0] in_dest,
  input  logic       in_has_dest,
  output logic [4:0] raddrRATsr1,
  output logic [4:0] raddrRATsr2,
  output logic [4:0] raddrRATdest,
  input  logic [5:0] rdataRATsr1,
  input  logic [5:0] rdataRATsr2,
  input  logic [5:0] rdataRATdest,
  output logic       wenRATdest,
  output logic [4:0] waddrRATdest,
  output logic [5:0] wdataRATdest,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_psr1,
  output logic [5:0] out_psr2,
  output logic [5:0] out_pdest,
  output logic [5:0] out_old_pdest,
  output logic       out_has_dest,
  input  logic       free_valid,
  input  logic [5:0] free_preg,
  output logic [5:0] fl_count,
  output logic       fl_overflow
);

  logic [5:0] fl [32];
  logic [4:0] head, tail;
  logic [5:0] count;
  logic       accept, alloc, full, free_ok;

  assign raddrRATsr1  = in_sr1;
  assign raddrRATsr2  = in_sr2;
  assign raddrRATdest = in_dest;
  assign fl_count     = count;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    in_ready     = 1'b0;
    accept       = 1'b0;
    alloc        = 1'b0;
    full         = 1'b0;
    free_ok      = 1'b0;
    wenRATdest   = 1'b0;
    waddrRATdest = in_dest;
    wdataRATdest = fl[head];

    in_ready   = (!out_valid || out_ready) && (count != 6'd0);
    accept     = in_valid && in_ready;
    alloc      = accept && in_has_dest && (in_dest != 5'd0);
    full       = (count == 6'd32);
    // A full list can still take a free when an allocation vacates a slot.
    free_ok    = free_valid && (!full || alloc);
    wenRATdest = alloc;
  end

  // NOTE: the free-list storage is reset because its contents (32..63) are
  // architecturally visible after reset, unlike ordinary scratch memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) fl[i] <= 6'(32 + i);
    end else if (free_ok) begin
      fl[tail] <= free_preg;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= 5'd0;
      tail        <= 5'd0;
      count       <= 6'd32;
      fl_overflow <= 1'b0;
    end else begin
      if (alloc)   head <= head + 5'd1;
      if (free_ok) tail <= tail + 5'd1;
      count <= count + 6'(free_ok) - 6'(alloc);
      if (free_valid && !free_ok) fl_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_psr1      <= 6'd0;
      out_psr2      <= 6'd0;
      out_pdest     <= 6'd0;
      out_old_pdest <= 6'd0;
      out_has_dest  <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_psr1      <= (in_sr1 == 5'd0) ? 6'd0 : rdataRATsr1;
      out_psr2      <= (in_sr2 == 5'd0) ? 6'd0 : rdataRATsr2;
      out_old_pdest <= rdataRATdest;
      out_pdest     <= alloc ? fl[head] : 6'd0;
      out_has_dest  <= alloc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rename_ctrl.sv
// Self-checking bench for rename_ctrl: a RAT stub, a queue-based free-list and
// map-table reference model, directed scenarios, then randomized traffic.
module tb_rename_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [4:0] in_sr1, in_sr2, in_dest;
  logic       in_has_dest;
  logic [4:0] raddrRATsr1, raddrRATsr2, raddrRATdest;
  logic [5:0] rdataRATsr1, rdataRATsr2, rdataRATdest;
  logic       wenRATdest;
  logic [4:0] waddrRATdest;
  logic [5:0] wdataRATdest;
  logic       out_valid, out_ready;
  logic [5:0] out_psr1, out_psr2, out_pdest, out_old_pdest;
  logic       out_has_dest;
  logic       free_valid;
  logic [5:0] free_preg;
  logic [5:0] fl_count;
  logic       fl_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rename_ctrl dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dest(in_dest), .in_has_dest(in_has_dest),
    .raddrRATsr1(raddrRATsr1), .raddrRATsr2(raddrRATsr2), .raddrRATdest(raddrRATdest),
    .rdataRATsr1(rdataRATsr1), .rdataRATsr2(rdataRATsr2), .rdataRATdest(rdataRATdest),
    .wenRATdest(wenRATdest), .waddrRATdest(waddrRATdest), .wdataRATdest(wdataRATdest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_psr1(out_psr1), .out_psr2(out_psr2), .out_pdest(out_pdest),
    .out_old_pdest(out_old_pdest), .out_has_dest(out_has_dest),
    .free_valid(free_valid), .free_preg(free_preg),
    .fl_count(fl_count), .fl_overflow(fl_overflow)
  );

  // RAT stub: combinational read, posedge write, identity on reset.
  logic [5:0] rat [32];
  assign rdataRATsr1  = rat[raddrRATsr1];
  assign rdataRATsr2  = rat[raddrRATsr2];
  assign rdataRATdest = rat[raddrRATdest];
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < 32; i++) rat[i] <= 6'(i);
    else if (wenRATdest) rat[waddrRATdest] <= wdataRATdest;
  end

  // Reference model state.
  int q[$];
  int ref_map [32];
  int m_psr1, m_psr2, m_pdest, m_old;
  bit m_valid, m_hd, m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(32 + i);
    for (int i = 0; i < 32; i++) ref_map[i] = i;
    m_psr1 = 0; m_psr2 = 0; m_pdest = 0; m_old = 0;
    m_valid = 0; m_hd = 0; m_ovf = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".out_valid"},     32'(out_valid),     32'(m_valid));
    check({tag, ".out_psr1"},      32'(out_psr1),      32'(m_psr1));
    check({tag, ".out_psr2"},      32'(out_psr2),      32'(m_psr2));
    check({tag, ".out_pdest"},     32'(out_pdest),     32'(m_pdest));
    check({tag, ".out_old_pdest"}, 32'(out_old_pdest), 32'(m_old));
    check({tag, ".out_has_dest"},  32'(out_has_dest),  32'(m_hd));
    check({tag, ".fl_count"},      32'(fl_count),      32'(q.size()));
    check({tag, ".fl_overflow"},   32'(fl_overflow),   32'(m_ovf));
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_has_dest = 1'b0; free_valid = 1'b0;
    in_sr1 = '0; in_sr2 = '0; in_dest = '0; free_preg = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_regs("reset");
    check("reset.wen", 32'(wenRATdest), 32'd0);
  endtask

  // One clock: drive, check combinational RAT/handshake outputs, advance model,
  // clock, then check registered outputs.
  task automatic step(input string tag, input bit v, input int s1, input int s2,
                      input int d, input bit hd, input bit ordy, input bit fv, input int fp);
    int  pre_cnt;
    bit  exp_ready, acc, al;
    in_valid = v; in_sr1 = 5'(s1); in_sr2 = 5'(s2); in_dest = 5'(d);
    in_has_dest = hd; out_ready = ordy; free_valid = fv; free_preg = 6'(fp);
    #1;
    pre_cnt   = q.size();
    exp_ready = (!m_valid || ordy) && (pre_cnt != 0);
    acc       = v && exp_ready;
    al        = acc && hd && (d != 0);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    check({tag, ".wen"},      32'(wenRATdest), 32'(al));
    check({tag, ".raddr1"},   32'(raddrRATsr1), 32'(s1));
    if (al) begin
      check({tag, ".waddr"}, 32'(waddrRATdest), 32'(d));
      check({tag, ".wdata"}, 32'(wdataRATdest), 32'(q[0]));
    end
    if (acc) begin
      m_psr1  = (s1 == 0) ? 0 : ref_map[s1];
      m_psr2  = (s2 == 0) ? 0 : ref_map[s2];
      m_old   = ref_map[d];
      m_pdest = al ? q[0] : 0;
      m_hd    = al;
      if (al) begin
        ref_map[d] = q[0];
        void'(q.pop_front());
      end
      m_valid = 1;
    end else if (ordy) begin
      m_valid = 0;
    end
    if (fv) begin
      if (pre_cnt == 32 && !al) m_ovf = 1;
      else q.push_back(fp);
    end
    @(posedge clk); #1;
    check_regs(tag);
  endtask

  initial begin
    model_reset();
    do_reset();

    // First rename after reset.
    step("t1", 1, 0, 16, 31, 1, 1, 0, 0);
    check("t1.psr1_c", 32'(out_psr1), 32'd0);
    check("t1.psr2_c", 32'(out_psr2), 32'd16);
    check("t1.old_c", 32'(out_old_pdest), 32'd31);
    check("t1.pdest_c", 32'(out_pdest), 32'd32);
    check("t1.rat31", 32'(rat[31]), 32'd32);

    // Back-to-back dependency.
    do_reset();
    step("b2b_a", 1, 1, 2, 5, 1, 1, 0, 0);
    step("b2b_b", 1, 5, 0, 5, 1, 1, 0, 0);
    check("b2b.psr1_c", 32'(out_psr1), 32'd32);
    check("b2b.old_c", 32'(out_old_pdest), 32'd32);
    check("b2b.pdest_c", 32'(out_pdest), 32'd33);
    check("b2b.count_c", 32'(fl_count), 32'd30);

    // Exhaust the free list, then free preg 7 while empty.
    do_reset();
    for (int i = 0; i < 32; i++) step("exh", 1, i, 0, (i % 31) + 1, 1, 1, 0, 0);
    check("exh.count_c", 32'(fl_count), 32'd0);
    step("exh_free", 1, 0, 0, 3, 1, 1, 1, 7);
    check("exh_free.count_c", 32'(fl_count), 32'd1);
    step("exh_alloc", 1, 0, 0, 4, 1, 1, 0, 0);
    check("exh_alloc.pdest_c", 32'(out_pdest), 32'd7);

    // Steady state at count 10 with simultaneous alloc and free.
    do_reset();
    for (int i = 0; i < 22; i++) step("ss_fill", 1, 0, 0, (i % 31) + 1, 1, 1, 0, 0);
    check("ss.count_c", 32'(fl_count), 32'd10);
    step("ss_af", 1, 2, 3, 9, 1, 1, 1, 45);
    check("ss_af.count_c", 32'(fl_count), 32'd10);
    for (int i = 0; i < 10; i++) step("ss_drain", 1, 0, 0, 6, 1, 1, 0, 0);
    check("ss_drain.tail_c", 32'(out_pdest), 32'd45);

    // Backpressure for three cycles, then release.
    do_reset();
    step("bp0", 1, 1, 2, 2, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("bp_hold", 1, 2, 3, 3, 1, 0, 0, 0);
    check("bp.pdest_c", 32'(out_pdest), 32'd32);
    for (int i = 0; i < 3; i++) step("bp_rel", 1, 2, 3, 3 + i, 1, 1, 0, 0);

    // No-destination cases and overflow on a full list.
    do_reset();
    step("d0", 1, 4, 5, 0, 1, 1, 1, 40);
    check("d0.ovf_c", 32'(fl_overflow), 32'd1);
    check("d0.count_c", 32'(fl_count), 32'd32);
    step("nohd", 1, 4, 5, 7, 0, 1, 0, 0);
    check("nohd.hd_c", 32'(out_has_dest), 32'd0);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(499) == 0) do_reset();
      step("rnd",
           $urandom_range(99) < 70, int'($urandom_range(31)), int'($urandom_range(31)),
           int'($urandom_range(31)), $urandom_range(99) < 80, $urandom_range(99) < 75,
           $urandom_range(99) < 50, int'($urandom_range(63)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
